axi_read_arbiter: RTL and testbench

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_read_arbiter.sv | 179 +++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// AXI read-channel arbiter: several requesters share one downstream AR/R port.
// AR requests are granted round-robin into a single-entry output register,
// each requester may have one burst in flight, and R beats are steered back
// to the requester named by RID without any buffering.
module axi_read_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_REQ-1:0]            req_arvalid,
    output logic [NUM_REQ-1:0]            req_arready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]          req_arlen,
    input  logic [NUM_REQ*3-1:0]          req_arsize,
    input  logic [NUM_REQ*2-1:0]          req_arburst,

    output logic [NUM_REQ-1:0]            req_rvalid,
    input  logic [NUM_REQ-1:0]            req_rready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [1:0]                    req_rresp,
    output logic                          req_rlast,

    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ID_WIDTH-1:0]           m_arid,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,

    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [ID_WIDTH-1:0]           m_rid,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,

    output logic [NUM_REQ-1:0]            busy,
    output logic                          err_rid
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // AR output slot:
    //   state    | meaning
    //   ST_EMPTY | no request held, m_arvalid low
    //   ST_FULL  | request held on m_ar*, waiting for m_arready
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_t;

    slot_t                 r_slot;
    logic [NUM_REQ-1:0]    r_busy;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [ID_WIDTH-1:0]   r_ar_id;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic [7:0]            r_ar_len;
    logic [2:0]            r_ar_size;
    logic [1:0]            r_ar_burst;

    logic [NUM_REQ-1:0]    w_eligible;
    logic                  w_slot_free;
    logic                  w_grant;
    logic [IDX_W-1:0]      w_winner;
    logic [IDX_W-1:0]      w_rr_next;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [7:0]            w_win_len;
    logic [2:0]            w_win_size;
    logic [1:0]            w_win_burst;
    logic [NUM_REQ-1:0]    w_busy_set;
    logic [NUM_REQ-1:0]    w_busy_clr;
    logic [NUM_REQ-1:0]    w_rid_hit;
    logic                  w_rid_ok;
    logic                  w_r_done;

    assign w_eligible  = req_arvalid & ~r_busy;
    assign w_slot_free = (r_slot == ST_EMPTY) || m_arready;
    // A grant can never be issued while reset is asserted.
    assign w_grant     = !rst && w_slot_free && (|w_eligible);

    // Round-robin search starting at r_rr_ptr, plus mux of the winner's AR fields.
    always_comb begin
        logic found;
        found       = 1'b0;
        w_winner    = '0;
        w_win_addr  = '0;
        w_win_len   = '0;
        w_win_size  = '0;
        w_win_burst = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && w_eligible[idx]) begin
                found    = 1'b1;
                w_winner = IDX_W'(idx);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_win_addr  = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_win_len   = req_arlen[i*8 +: 8];
                w_win_size  = req_arsize[i*3 +: 3];
                w_win_burst = req_arburst[i*2 +: 2];
            end
        end
    end

    assign w_rr_next = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + IDX_W'(1);

    // One-hot decode of the grant and of the R-channel ID.
    always_comb begin
        w_busy_set = '0;
        w_rid_hit  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_busy_set[i] = w_grant && (w_winner == IDX_W'(i));
            w_rid_hit[i]  = (m_rid == ID_WIDTH'(i));
        end
    end

    assign req_arready = w_busy_set;

    // R routing is purely combinational; beats with an unknown RID are sunk.
    assign w_rid_ok   = |w_rid_hit;
    assign req_rvalid = w_rid_hit & {NUM_REQ{m_rvalid}};
    assign m_rready   = w_rid_ok ? |(w_rid_hit & req_rready) : 1'b1;
    assign req_rdata  = m_rdata;
    assign req_rresp  = m_rresp;
    assign req_rlast  = m_rlast;
    assign err_rid    = !rst && m_rvalid && !w_rid_ok;

    // Last beat frees the owning requester; out-of-range RIDs match nobody.
    assign w_r_done   = m_rvalid && m_rready && m_rlast;
    assign w_busy_clr = w_rid_hit & {NUM_REQ{w_r_done}};

    // AR slot FSM, round-robin pointer and per-requester busy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot     <= ST_EMPTY;
            r_busy     <= '0;
            r_rr_ptr   <= '0;
            r_ar_id    <= '0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
        end else begin
            if (w_grant) begin
                r_slot     <= ST_FULL;
                r_rr_ptr   <= w_rr_next;
                r_ar_id    <= ID_WIDTH'(w_winner);
                r_ar_addr  <= w_win_addr;
                r_ar_len   <= w_win_len;
                r_ar_size  <= w_win_size;
                r_ar_burst <= w_win_burst;
            end else if ((r_slot == ST_FULL) && m_arready) begin
                r_slot <= ST_EMPTY;
            end
            // A new grant wins over a stray last beat for the same requester.
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    assign m_arvalid = (r_slot == ST_FULL);
    assign m_arid    = r_ar_id;
    assign m_araddr  = r_ar_addr;
    assign m_arlen   = r_ar_len;
    assign m_arsize  = r_ar_size;
    assign m_arburst = r_ar_burst;
    assign busy      = r_busy;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter with hand-computed expectations.
module tb_axi_read_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_arvalid;
    logic [2:0]  req_arready;
    logic [31:0] a_addr [3];
    logic [7:0]  a_len  [3];
    logic [2:0]  a_size [3];
    logic [1:0]  a_burst[3];
    logic [2:0]  req_rvalid;
    logic [2:0]  req_rready;
    logic [63:0] req_rdata;
    logic [1:0]  req_rresp;
    logic        req_rlast;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid;
    logic        m_rready;
    logic [3:0]  m_rid;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic [2:0]  busy;
    logic        err_rid;

    int n_tests = 0;
    int n_fail  = 0;

    axi_read_arbiter #(
        .NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_arvalid(req_arvalid),
        .req_arready(req_arready),
        .req_araddr ({a_addr[2], a_addr[1], a_addr[0]}),
        .req_arlen  ({a_len[2], a_len[1], a_len[0]}),
        .req_arsize ({a_size[2], a_size[1], a_size[0]}),
        .req_arburst({a_burst[2], a_burst[1], a_burst[0]}),
        .req_rvalid (req_rvalid),
        .req_rready (req_rready),
        .req_rdata  (req_rdata),
        .req_rresp  (req_rresp),
        .req_rlast  (req_rlast),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_arid     (m_arid),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_arsize   (m_arsize),
        .m_arburst  (m_arburst),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_rid      (m_rid),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp),
        .m_rlast    (m_rlast),
        .busy       (busy),
        .err_rid    (err_rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge; checks happen 1 ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_arvalid = '0;
        req_rready  = '0;
        m_arready   = 1'b0;
        m_rvalid    = 1'b0;
        m_rid       = '0;
        m_rdata     = '0;
        m_rresp     = '0;
        m_rlast     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_addr[i]  = 32'h1000 * (i + 1);
            a_len[i]   = 8'(i + 1);
            a_size[i]  = 3'd3;
            a_burst[i] = 2'd1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        req_arvalid = 3'b111;
        m_rvalid = 1'b1; m_rid = 4'd1; req_rready = 3'b010;
        #1;
        n_tests++; if (req_arready !== 3'b000) begin n_fail++; $display("FAIL rst_arready: got %b exp 000", req_arready); end
        n_tests++; if (m_rready !== 1'b1) begin n_fail++; $display("FAIL rst_rready_passthru: got %b exp 1", m_rready); end
        n_tests++; if (req_rvalid !== 3'b010) begin n_fail++; $display("FAIL rst_rvalid_passthru: got %b exp 010", req_rvalid); end
        tick();
        n_tests++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b exp 0", m_arvalid); end
        n_tests++; if (busy !== 3'b000) begin n_fail++; $display("FAIL rst_busy: got %b exp 000", busy); end
        n_tests++; if (m_araddr !== 32'h0) begin n_fail++; $display("FAIL rst_araddr: got %h exp 0", m_araddr); end
        m_rid = 4'd5;
        #1;
        n_tests++; if (err_rid !== 1'b0) begin n_fail++; $display("FAIL rst_err_rid: got %b exp 0", err_rid); end
        n_tests++; if (m_rready !== 1'b1) begin n_fail++; $display("FAIL rst_rready_oob: got %b exp 1", m_rready); end
        do_reset();
    endtask

    task automatic test_round_robin();
        do_reset();
        req_arvalid = 3'b111; m_arready = 1'b1;
        #1;
        n_tests++; if (req_arready !== 3'b001) begin n_fail++; $display("FAIL rr_t0_arready: got %b exp 001", req_arready); end
        n_tests++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL rr_t0_arvalid: got %b exp 0", m_arvalid); end
        tick();
        req_arvalid = 3'b110;
        #1;
        n_tests++; if (m_arvalid !== 1'b1 || m_arid !== 4'd0) begin n_fail++; $display("FAIL rr_t1_arid: got v=%b id=%0d exp v=1 id=0", m_arvalid, m_arid); end
        n_tests++; if (m_araddr !== 32'h1000 || m_arlen !== 8'd1) begin n_fail++; $display("FAIL rr_t1_fields: got %h/%0d exp 1000/1", m_araddr, m_arlen); end
        n_tests++; if (req_arready !== 3'b010) begin n_fail++; $display("FAIL rr_t1_arready: got %b exp 010", req_arready); end
        tick();
        req_arvalid = 3'b100;
        #1;
        n_tests++; if (m_arid !== 4'd1 || m_araddr !== 32'h2000 || m_arlen !== 8'd2) begin n_fail++; $display("FAIL rr_t2_ar: got id=%0d %h/%0d exp id=1 2000/2", m_arid, m_araddr, m_arlen); end
        n_tests++; if (req_arready !== 3'b100) begin n_fail++; $display("FAIL rr_t2_arready: got %b exp 100", req_arready); end
        n_tests++; if (busy !== 3'b011) begin n_fail++; $display("FAIL rr_t2_busy: got %b exp 011", busy); end
        tick();
        req_arvalid = 3'b000;
        #1;
        n_tests++; if (m_arid !== 4'd2 || m_araddr !== 32'h3000 || m_arsize !== 3'd3 || m_arburst !== 2'd1) begin n_fail++; $display("FAIL rr_t3_ar: got id=%0d %h sz=%0d bu=%0d exp id=2 3000 sz=3 bu=1", m_arid, m_araddr, m_arsize, m_arburst); end
        n_tests++; if (busy !== 3'b111 || req_arready !== 3'b000) begin n_fail++; $display("FAIL rr_t3_busy: got busy=%b rdy=%b exp 111/000", busy, req_arready); end
        tick();
        #1;
        n_tests++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL rr_t4_empty: got %b exp 0", m_arvalid); end
    endtask

    task automatic test_busy_reissue();
        do_reset();
        req_arvalid = 3'b001; m_arready = 1'b1;
        #1;
        n_tests++; if (req_arready !== 3'b001) begin n_fail++; $display("FAIL busy_t0_grant: got %b exp 001", req_arready); end
        tick();
        #1;
        n_tests++; if (busy !== 3'b001 || req_arready !== 3'b000) begin n_fail++; $display("FAIL busy_t1: got busy=%b rdy=%b exp 001/000", busy, req_arready); end
        tick();
        #1;
        n_tests++; if (m_arvalid !== 1'b0 || req_arready !== 3'b000) begin n_fail++; $display("FAIL busy_t2: got v=%b rdy=%b exp 0/000", m_arvalid, req_arready); end
        tick();
        m_rvalid = 1'b1; m_rid = 4'd0; m_rlast = 1'b0; req_rready = 3'b001;
        #1;
        n_tests++; if (m_rready !== 1'b1 || req_rvalid !== 3'b001) begin n_fail++; $display("FAIL busy_t3_beat: got rr=%b rv=%b exp 1/001", m_rready, req_rvalid); end
        tick();
        m_rvalid = 1'b0;
        #1;
        n_tests++; if (busy !== 3'b001) begin n_fail++; $display("FAIL busy_t4_nonlast: got %b exp 001", busy); end
        tick();
        m_rvalid = 1'b1; m_rid = 4'd0; m_rlast = 1'b1;
        #1;
        n_tests++; if (req_arready !== 3'b000) begin n_fail++; $display("FAIL busy_t5_arready: got %b exp 000", req_arready); end
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        n_tests++; if (busy !== 3'b000 || req_arready !== 3'b001) begin n_fail++; $display("FAIL busy_t6: got busy=%b rdy=%b exp 000/001", busy, req_arready); end
        tick();
        req_arvalid = 3'b000;
        #1;
        n_tests++; if (m_arvalid !== 1'b1 || m_arid !== 4'd0 || busy !== 3'b001) begin n_fail++; $display("FAIL busy_t7: got v=%b id=%0d busy=%b exp 1/0/001", m_arvalid, m_arid, busy); end
    endtask

    task automatic test_stall();
        do_reset();
        a_addr[1] = 32'h8000_0040; a_len[1] = 8'd7;
        req_arvalid = 3'b010; m_arready = 1'b0;
        #1;
        n_tests++; if (req_arready !== 3'b010) begin n_fail++; $display("FAIL stall_t0_grant: got %b exp 010", req_arready); end
        tick();
        req_arvalid = 3'b101;
        a_addr[1] = 32'hFFFF_FFFF; a_len[1] = 8'd0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_tests++; if (m_arvalid !== 1'b1 || m_arid !== 4'd1) begin n_fail++; $display("FAIL stall_c%0d_valid: got v=%b id=%0d exp 1/1", c, m_arvalid, m_arid); end
            n_tests++; if (m_araddr !== 32'h8000_0040 || m_arlen !== 8'd7) begin n_fail++; $display("FAIL stall_c%0d_fields: got %h/%0d exp 80000040/7", c, m_araddr, m_arlen); end
            n_tests++; if (req_arready !== 3'b000) begin n_fail++; $display("FAIL stall_c%0d_nogrant: got %b exp 000", c, req_arready); end
            tick();
        end
        m_arready = 1'b1;
        #1;
        n_tests++; if (req_arready !== 3'b100) begin n_fail++; $display("FAIL stall_b2b_grant: got %b exp 100", req_arready); end
        tick();
        #1;
        n_tests++; if (m_arvalid !== 1'b1 || m_arid !== 4'd2 || m_araddr !== 32'h3000) begin n_fail++; $display("FAIL stall_b2b_reload: got v=%b id=%0d %h exp 1/2/3000", m_arvalid, m_arid, m_araddr); end
        n_tests++; if (req_arready !== 3'b001) begin n_fail++; $display("FAIL stall_b2b_next: got %b exp 001", req_arready); end
        tick();
        req_arvalid = 3'b000;
        #1;
        n_tests++; if (m_arid !== 4'd0 || busy !== 3'b111) begin n_fail++; $display("FAIL stall_b2b_last: got id=%0d busy=%b exp 0/111", m_arid, busy); end
    endtask

    task automatic test_r_routing();
        do_reset();
        req_arvalid = 3'b010; m_arready = 1'b1;
        tick();
        req_arvalid = 3'b000;
        tick();
        m_rvalid = 1'b1; m_rid = 4'd1; m_rlast = 1'b0;
        m_rdata = 64'hDEAD_BEEF_0123_4567; m_rresp = 2'b10; req_rready = 3'b010;
        #1;
        n_tests++; if (req_rvalid !== 3'b010 || m_rready !== 1'b1) begin n_fail++; $display("FAIL r_rid1: got rv=%b rr=%b exp 010/1", req_rvalid, m_rready); end
        n_tests++; if (req_rdata !== 64'hDEAD_BEEF_0123_4567 || req_rresp !== 2'b10 || req_rlast !== 1'b0) begin n_fail++; $display("FAIL r_payload: got %h/%b/%b exp deadbeef01234567/10/0", req_rdata, req_rresp, req_rlast); end
        n_tests++; if (err_rid !== 1'b0) begin n_fail++; $display("FAIL r_rid1_err: got %b exp 0", err_rid); end
        req_rready = 3'b101;
        #1;
        n_tests++; if (m_rready !== 1'b0) begin n_fail++; $display("FAIL r_rid1_backpressure: got %b exp 0", m_rready); end
        tick();
        m_rid = 4'd5; m_rlast = 1'b1; req_rready = 3'b000;
        #1;
        n_tests++; if (m_rready !== 1'b1 || req_rvalid !== 3'b000 || err_rid !== 1'b1) begin n_fail++; $display("FAIL r_rid5: got rr=%b rv=%b err=%b exp 1/000/1", m_rready, req_rvalid, err_rid); end
        tick();
        m_rid = 4'd2; m_rlast = 1'b1; req_rready = 3'b100;
        #1;
        n_tests++; if (busy !== 3'b010 || err_rid !== 1'b0) begin n_fail++; $display("FAIL r_rid5_busy: got busy=%b err=%b exp 010/0", busy, err_rid); end
        n_tests++; if (req_rvalid !== 3'b100 || m_rready !== 1'b1) begin n_fail++; $display("FAIL r_stray_route: got rv=%b rr=%b exp 100/1", req_rvalid, m_rready); end
        tick();
        m_rid = 4'd1; m_rlast = 1'b1; req_rready = 3'b010;
        #1;
        n_tests++; if (busy !== 3'b010) begin n_fail++; $display("FAIL r_stray_busy: got %b exp 010", busy); end
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        n_tests++; if (busy !== 3'b000) begin n_fail++; $display("FAIL r_rid1_last: got %b exp 000", busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_arvalid = 3'b011; m_arready = 1'b0;
        tick();
        req_arvalid = 3'b010; m_arready = 1'b1;
        tick();
        req_arvalid = 3'b000; m_arready = 1'b0;
        #1;
        n_tests++; if (busy !== 3'b011 || m_arvalid !== 1'b1 || m_arid !== 4'd1) begin n_fail++; $display("FAIL rmid_pre: got busy=%b v=%b id=%0d exp 011/1/1", busy, m_arvalid, m_arid); end
        rst = 1'b1; req_arvalid = 3'b111;
        #1;
        n_tests++; if (req_arready !== 3'b000) begin n_fail++; $display("FAIL rmid_rst_arready: got %b exp 000", req_arready); end
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (m_arvalid !== 1'b0 || busy !== 3'b000 || m_araddr !== 32'h0) begin n_fail++; $display("FAIL rmid_post: got v=%b busy=%b addr=%h exp 0/000/0", m_arvalid, busy, m_araddr); end
        n_tests++; if (req_arready !== 3'b001) begin n_fail++; $display("FAIL rmid_first_grant: got %b exp 001", req_arready); end
        tick();
        req_arvalid = 3'b000;
        #1;
        n_tests++; if (m_arid !== 4'd0 || m_arvalid !== 1'b1) begin n_fail++; $display("FAIL rmid_arid: got id=%0d v=%b exp 0/1", m_arid, m_arvalid); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_busy_reissue();
        test_stall();
        test_r_routing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
